// File: rtl/rs485_dir_ctrl.sv
// rs485_dir_ctrl: half-duplex RS-485 DE/RE sequencer with setup/hold/turnaround timing; define RS485_ECHO_CHECK_EN for echo collision checking
module rs485_dir_ctrl #(
  parameter int unsigned SETUP_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned TURN_CYCLES  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_req,
  input  logic tx_busy,
  output logic tx_grant,
  input  logic di,
  input  logic ro_in,
  output logic ro_out,
  output logic de,
  output logic re,
  output logic collision
);
  typedef enum logic [2:0] {IDLE, SETUP, TX, HOLD, TURN} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t SETUP_N = cnt_t'(SETUP_CYCLES);
  localparam cnt_t HOLD_N  = cnt_t'(HOLD_CYCLES);
  localparam cnt_t TURN_N  = cnt_t'(TURN_CYCLES);
  localparam state_t SETUP_ST = (SETUP_CYCLES == 0) ? TX : SETUP;
  localparam state_t HOLD_ST  = (HOLD_CYCLES == 0) ? TURN : HOLD;
  localparam state_t TURN_ST  = (TURN_CYCLES == 0) ? IDLE : TURN;
  if ((SETUP_CYCLES >> CNT_W) != 0 || (HOLD_CYCLES >> CNT_W) != 0 || (TURN_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
    $error("rs485_dir_ctrl: a *_CYCLES value does not fit in CNT_W bits");
  end
  state_t state, nxt;
  cnt_t cnt, cnt_nxt;
  logic ro_s1;
  // next state and counter reload; a zero hold still spends one cycle in TURN so DE drops before RE
  always_comb begin
    nxt = state;
    cnt_nxt = (cnt != '0) ? cnt - cnt_t'(1) : cnt;
    case (state)
      IDLE: if (tx_req) begin
        nxt = SETUP_ST;
        cnt_nxt = SETUP_N;
      end
      SETUP: nxt = (cnt <= cnt_t'(1)) ? TX : SETUP;
      TX: if (!tx_req && !tx_busy) begin
        nxt = HOLD_ST;
        cnt_nxt = (HOLD_CYCLES == 0) ? TURN_N : HOLD_N;
      end
      HOLD: if (tx_req) nxt = TX;
      else if (cnt <= cnt_t'(1)) begin
        nxt = TURN_ST;
        cnt_nxt = TURN_N;
      end
      TURN: if (tx_req) begin
        nxt = SETUP_ST;
        cnt_nxt = SETUP_N;
      end else if (cnt <= cnt_t'(1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state register with outputs registered from the next state; ro_out doubles as the second sync flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      de <= 1'b0;
      tx_grant <= 1'b0;
      ro_s1 <= 1'b1;
      ro_out <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      de <= nxt inside {SETUP, TX, HOLD};
      tx_grant <= nxt == TX;
      ro_s1 <= ro_in;
      ro_out <= (nxt == IDLE) ? ro_s1 : 1'b1;
    end
  end
`ifdef RS485_ECHO_CHECK_EN
  logic ro_s;
  logic [1:0] di_d;
  logic [1:0] tx_age;
  assign re = 1'b0;
  // unmasked echo path, aligned TX data and TX age gating the mismatch check
  always_ff @(posedge clk) begin
    if (rst) begin
      ro_s <= 1'b1;
      di_d <= 2'b11;
      tx_age <= 2'd0;
      collision <= 1'b0;
    end else begin
      ro_s <= ro_s1;
      di_d <= {di_d[0], di};
      tx_age <= (state == TX && nxt == TX) ? ((tx_age == 2'd3) ? tx_age : tx_age + 2'd1) : 2'd0;
      collision <= state == TX && tx_age >= 2'd2 && ro_s != di_d[1];
    end
  end
`else
  logic di_unused;
  assign di_unused = di;
  assign collision = 1'b0;
  // receiver is off whenever the sequencer is not idle
  always_ff @(posedge clk) begin
    if (rst) re <= 1'b0;
    else re <= nxt != IDLE;
  end
`endif
endmodule
